count_up_timer: RTL and testbench

- Stopwatch-style up-counter: the count-up counterpart of the board's countdown timer.
- Driven by the same user buttons and the same scaled time base.
- Counts elapsed ticks from 0 toward a programmable target, then raises a done flag.
- Feeds the existing LED/seven-segment display path; the top level sits between it and CLOCK_50/KEY/SW.

---
 rtl/timer_pkg.sv | 16 +
 rtl/tick_gen.sv | 32 +++
 rtl/count_up_timer.sv | 99 +++++++++
 tb/tb_count_up_timer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the board's up- and down-counting timers.
// Holds the state encoding, clock rate and default tick scaling.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} timer_state_t;

  localparam int CLK_HZ               = 50_000_000;
  localparam int DEFAULT_SCALE_FACTOR = 50_000;
  localparam int DEFAULT_WIDTH        = 11;

  // A scale of 1 still needs a one-bit prescaler register.
  function automatic int prescaler_width(input int scale);
    return (scale > 1) ? $clog2(scale) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that strobes tick once every SCALE_FACTOR enabled cycles.
// Holds its phase while disabled; clear zeroes it on the next edge.
module tick_gen
  import timer_pkg::*;
#(
  parameter int SCALE_FACTOR = DEFAULT_SCALE_FACTOR
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = prescaler_width(SCALE_FACTOR);
  localparam logic [PW-1:0] LAST = PW'(SCALE_FACTOR - 1);

  logic [PW-1:0] prescaler;

  assign tick = enable && (prescaler == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (clear) begin
      prescaler <= '0;
    end else if (enable) begin
      prescaler <= (prescaler == LAST) ? '0 : prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/count_up_timer.sv
// Stopwatch-style up-counter: counts prescaled ticks from 0 to a latched
// target, with a start/stop toggle button, pause, and synchronous clear.
module count_up_timer
  import timer_pkg::*;
#(
  parameter int SCALE_FACTOR = DEFAULT_SCALE_FACTOR,
  parameter int WIDTH        = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             tick
);

  timer_state_t     state;
  logic             start_stop_d;
  logic             press;
  logic             presc_enable;
  logic             presc_clear;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] count_inc;

  assign press     = start_stop & ~start_stop_d;
  assign count_inc = count + 1'b1;

  // Clear must win over a wrap in the same cycle, so it also gates the enable.
  assign presc_enable = (state == RUNNING) && !clear;
  assign presc_clear  = clear || (state == IDLE) || (state == DONE);

  tick_gen #(
    .SCALE_FACTOR(SCALE_FACTOR)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_enable),
    .clear  (presc_clear),
    .tick   (tick)
  );

  // running/done follow the state register with one cycle of lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      target_q     <= '0;
      start_stop_d <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_stop_d <= start_stop;
      running      <= (state == RUNNING);
      done         <= (state == DONE);
      if (clear) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              target_q <= target;
              count    <= '0;
              state    <= (target == '0) ? DONE : RUNNING;
            end
          end
          RUNNING: begin
            // A tick landing with a press counts first; reaching target beats pausing.
            if (tick) begin
              count <= count_inc;
              if (count_inc == target_q) begin
                state <= DONE;
              end else if (press) begin
                state <= PAUSED;
              end
            end else if (press) begin
              state <= PAUSED;
            end
          end
          PAUSED: begin
            if (press) begin
              state <= RUNNING;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_up_timer.sv
// Scoreboard bench for count_up_timer: stimulus queues expected output
// changes (with cycle offsets); a negedge monitor pops and compares them.
module tb_count_up_timer;

  localparam int SF = 4;
  localparam int W  = 11;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic         start_stop = 1'b0;
  logic         clear      = 1'b0;
  logic [W-1:0] target     = '0;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic         tick;

  count_up_timer #(
    .SCALE_FACTOR(SF),
    .WIDTH       (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .target     (target),
    .count      (count),
    .running    (running),
    .done       (done),
    .tick       (tick)
  );

  typedef struct {
    int off;
    int cnt;
    bit run;
    bit dn;
  } evt_t;

  evt_t         exp_q[$];
  int           assertions = 0;
  int           failures   = 0;
  int           cyc        = 0;
  int           mark       = 0;
  int           tick_count = 0;
  int           t0         = 0;
  bit           mon_en     = 1'b0;
  logic [W+1:0] prev_snap  = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every change of {count, running, done} must match the next queued event.
  always @(negedge clk) begin
    logic [W+1:0] snap;
    evt_t         e;
    if (tick === 1'b1) tick_count++;
    snap = {count, running, done};
    if (mon_en && (snap !== prev_snap)) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event: got off=%0d count=%0d running=%b done=%b, required no change",
                 cyc - mark, count, running, done);
      end else begin
        e = exp_q.pop_front();
        if ((e.off != cyc - mark) || (count !== W'(e.cnt)) || (running !== e.run) || (done !== e.dn)) begin
          failures++;
          $display("[TB] FAIL event_off%0d: got off=%0d count=%0d running=%b done=%b, required off=%0d count=%0d running=%b done=%b",
                   e.off, cyc - mark, count, running, done, e.off, e.cnt, e.run, e.dn);
        end
      end
    end
    prev_snap = snap;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ss, input logic clr, input logic [W-1:0] tgt);
    start_stop = ss;
    clear      = clr;
    target     = tgt;
  endtask

  task automatic press_button();
    start_stop = 1'b1;
    wait_cycles(1);
    start_stop = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0;
  endtask

  task automatic push_expected(input int off, input int cnt, input bit run, input bit dn);
    evt_t e;
    e.off = off;
    e.cnt = cnt;
    e.run = run;
    e.dn  = dn;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int exp_cnt, input logic exp_run,
                             input logic exp_done, input logic exp_tick);
    assertions++;
    if ((count !== W'(exp_cnt)) || (running !== exp_run) || (done !== exp_done) || (tick !== exp_tick)) begin
      failures++;
      $display("[TB] FAIL %s: got count=%0d running=%b done=%b tick=%b, required count=%0d running=%b done=%b tick=%b",
               name, count, running, done, tick, exp_cnt, exp_run, exp_done, exp_tick);
    end
  endtask

  task automatic checkTally(input string name, input int got, input int want);
    assertions++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    checkOutput("reset_state", 0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Run to target 3.
    applyStimulus(1'b0, 1'b0, W'(3));
    wait_cycles(1);
    t0   = tick_count;
    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    push_expected(4, 1, 1, 0);
    push_expected(8, 2, 1, 0);
    push_expected(12, 3, 1, 0);
    push_expected(13, 3, 0, 1);
    push_expected(16, 0, 0, 1);
    push_expected(17, 0, 0, 0);
    press_button();
    wait_cycles(15);
    checkOutput("done_hold", 3, 1'b0, 1'b1, 1'b0);
    clear_pulse();
    wait_cycles(3);
    checkTally("run_ticks", tick_count - t0, 3);
    checkTally("q_drained_run", exp_q.size(), 0);

    // Pause and resume with target 10; a later target change must be ignored.
    applyStimulus(1'b0, 1'b0, W'(10));
    wait_cycles(1);
    t0   = tick_count;
    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    push_expected(4, 1, 1, 0);
    push_expected(8, 2, 1, 0);
    push_expected(11, 2, 0, 0);
    push_expected(32, 2, 1, 0);
    for (int k = 3; k <= 10; k++) push_expected(33 + 4 * (k - 3), k, 1, 0);
    push_expected(62, 10, 0, 1);
    push_expected(67, 0, 0, 1);
    push_expected(68, 0, 0, 0);
    press_button();
    applyStimulus(1'b0, 1'b0, W'(3));
    wait_cycles(9);
    press_button();
    wait_cycles(10);
    checkOutput("paused_frozen", 2, 1'b0, 1'b0, 1'b0);
    wait_cycles(10);
    press_button();
    wait_cycles(35);
    checkOutput("done_at_ten", 10, 1'b0, 1'b1, 1'b0);
    clear_pulse();
    wait_cycles(2);
    checkTally("pause_ticks", tick_count - t0, 10);
    checkTally("q_drained_pause", exp_q.size(), 0);

    // Button held for 50 cycles gives a single press.
    applyStimulus(1'b0, 1'b0, W'(100));
    wait_cycles(1);
    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    for (int k = 1; k <= 12; k++) push_expected(4 * k, k, 1, 0);
    push_expected(50, 0, 1, 0);
    push_expected(51, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, W'(100));
    wait_cycles(50);
    applyStimulus(1'b0, 1'b0, W'(100));
    checkOutput("held_still_running", 12, 1'b1, 1'b0, 1'b0);
    clear_pulse();
    wait_cycles(2);
    checkTally("q_drained_held", exp_q.size(), 0);

    // Zero target goes straight to DONE; presses in DONE are ignored.
    applyStimulus(1'b0, 1'b0, W'(0));
    wait_cycles(1);
    t0   = tick_count;
    mark = cyc + 1;
    push_expected(1, 0, 0, 1);
    push_expected(8, 0, 0, 0);
    press_button();
    wait_cycles(1);
    checkOutput("zero_target_done", 0, 1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    press_button();
    wait_cycles(3);
    checkOutput("done_ignores_press", 0, 1'b0, 1'b1, 1'b0);
    clear_pulse();
    wait_cycles(2);
    checkTally("zero_target_ticks", tick_count - t0, 0);
    checkTally("q_drained_zero", exp_q.size(), 0);

    // Clear and press together at count 5: clear wins.
    applyStimulus(1'b0, 1'b0, W'(100));
    wait_cycles(1);
    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) push_expected(4 * k, k, 1, 0);
    push_expected(21, 0, 1, 0);
    push_expected(22, 0, 0, 0);
    press_button();
    wait_cycles(20);
    checkOutput("pre_clear_count5", 5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, W'(100));
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, W'(100));
    wait_cycles(2);
    checkOutput("clear_priority", 0, 1'b0, 1'b0, 1'b0);
    checkTally("q_drained_clear", exp_q.size(), 0);

    // Asynchronous reset mid-prescaler at count 7, then a fresh start.
    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    for (int k = 1; k <= 7; k++) push_expected(4 * k, k, 1, 0);
    push_expected(30, 0, 0, 0);
    press_button();
    wait_cycles(30);
    checkOutput("pre_reset_count7", 7, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    reset = 1'b0;
    t0 = tick_count;
    wait_cycles(6);
    checkTally("no_stale_tick", tick_count - t0, 0);
    checkOutput("after_reset_idle", 0, 1'b0, 1'b0, 1'b0);
    checkTally("q_drained_reset", exp_q.size(), 0);

    mark = cyc + 1;
    push_expected(1, 0, 1, 0);
    push_expected(4, 1, 1, 0);
    push_expected(8, 2, 1, 0);
    press_button();
    wait_cycles(9);
    checkOutput("restart_count2", 2, 1'b1, 1'b0, 1'b0);
    checkTally("q_drained_restart", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
